// File: rtl/cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
//   Shared types and constants for the serial configuration chain loader.
//   - cfg_loader_state_t : loader FSM states
//   - CFG_BITS_PER_CELL  : cfg_bits contributed by one fabric cell
//   - CRC_POLY           : CRC-8 polynomial for the optional bitstream check
//   - crc8_step          : one bit-serial CRC-8 update (MSB-out, no reflection)
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        HIGH,
        HOLD,
        DONE
    } cfg_loader_state_t;

    localparam int         CFG_BITS_PER_CELL = 5;
    localparam logic [7:0] CRC_POLY          = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) != 1'b0) ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_chain_loader_timer.sv
// ---------------------------------------------------------------------------
// cfg_phase_timer
//   Loadable down-counter that times the SETUP / HIGH / HOLD phases of one
//   cfg_clk period. Loading N makes 'expired' assert in the (N+1)-th cycle of
//   the phase, so a phase of C cycles is loaded with C-1.
// Ports
//   clk_i     in   system clock
//   rst_i     in   asynchronous active-high reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   CNT_W  value loaded
//   expired   out  counter is zero
// ---------------------------------------------------------------------------
module cfg_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader
//   Drives the head of the serial configuration chain. Bitstream words arrive
//   over a valid/ready stream; each word is shifted out LSB-first on
//   cfg_value_o with a registered cfg_clk_o so each cfg_bit captures on the
//   cfg_clk_o rising edge. cfg_value_o only changes while cfg_clk_o is low and
//   never in the same cycle as cfg_clk_o.
// Ports
//   clk_i          in   system clock
//   rst_i          in   asynchronous active-high reset (aborts a load)
//   start_i        in   begin a full chain load (honoured in IDLE/DONE only)
//   data_i         in   WORD_W bitstream word
//   data_valid_i   in   data_i valid
//   data_ready_o   out  word accepted this cycle (high in FETCH)
//   cfg_clk_o      out  chain shift clock
//   cfg_value_o    out  chain serial data
//   busy_o         out  load in progress
//   crc_o          out  8-bit CRC of shifted bits (only with CFG_LOADER_CRC_EN)
//   done_o         out  last load completed (level)
// Build option
//   CFG_LOADER_CRC_EN : adds crc_o, a CRC-8 over every bit at its cfg_clk rise.
// ---------------------------------------------------------------------------
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = CFG_BITS_PER_CELL,
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              cfg_clk_o,
    output logic              cfg_value_o,
    output logic              busy_o,
`ifdef CFG_LOADER_CRC_EN
    output logic [7:0]        crc_o,
`endif
    output logic              done_o
);

    localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((HIGH_CYC > HOLD_CYC) ? HIGH_CYC : HOLD_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 1);
    localparam int BS_W  = $clog2(CHAIN_LEN + 1);
    localparam int BL_W  = $clog2(WORD_W + 1);

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] HIGH_LD  = TMR_W'(HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
    localparam logic [BS_W-1:0]  ALL_BITS = BS_W'(CHAIN_LEN);

    cfg_loader_state_t state_q, state_d;

    logic [BS_W-1:0]   bits_sent_q;
    logic [BL_W-1:0]   bits_left_q;
    logic [WORD_W-1:0] sreg_q;
    logic [WORD_W-1:0] sreg_shift;
    logic              cfg_clk_q;
    logic              cfg_value_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    logic              start_ok;
    logic              accept;
    logic              rise;
    logic              fall;
    logic              hold_end;

    logic [31:0]       remaining;
    logic [BL_W-1:0]   word_bits;

    cfg_phase_timer #(
        .CNT_W(TMR_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // The final word may carry fewer useful bits than WORD_W; its spare high
    // bits are never shifted.
    always_comb begin
        remaining = 32'(CHAIN_LEN) - 32'(bits_sent_q);
        word_bits = (remaining > 32'(WORD_W)) ? BL_W'(WORD_W) : BL_W'(remaining);
    end

    assign sreg_shift = sreg_q >> 1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;
        start_ok = 1'b0;
        accept   = 1'b0;
        rise     = 1'b0;
        fall     = 1'b0;
        hold_end = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (data_valid_i) begin
                    accept   = 1'b1;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (tmr_expired) begin
                    rise     = 1'b1;
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_LD;
                end
            end
            HIGH: begin
                if (tmr_expired) begin
                    fall     = 1'b1;
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_expired) begin
                    hold_end = 1'b1;
                    // bits_sent_q already counts the bit that just fell.
                    if (bits_sent_q == ALL_BITS) begin
                        state_d = DONE;
                    end else if (bits_left_q == '0) begin
                        state_d = FETCH;
                    end else begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_sent_q <= '0;
            bits_left_q <= '0;
            sreg_q      <= '0;
            cfg_clk_q   <= 1'b0;
            cfg_value_q <= 1'b0;
        end else begin
            if (start_ok) begin
                bits_sent_q <= '0;
            end
            if (accept) begin
                sreg_q      <= data_i;
                bits_left_q <= word_bits;
                cfg_value_q <= data_i[0];
            end
            if (rise) begin
                cfg_clk_q <= 1'b1;
            end
            if (fall) begin
                cfg_clk_q   <= 1'b0;
                bits_sent_q <= bits_sent_q + 1'b1;
                bits_left_q <= bits_left_q - 1'b1;
            end
            if (hold_end) begin
                if (bits_sent_q == ALL_BITS) begin
                    cfg_value_q <= 1'b0;
                end else if (bits_left_q != '0) begin
                    sreg_q      <= sreg_shift;
                    cfg_value_q <= sreg_shift[0];
                end
            end
        end
    end

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 8'h00;
        end else if (start_ok) begin
            crc_q <= 8'h00;
        end else if (rise) begin
            crc_q <= crc8_step(crc_q, cfg_value_q);
        end
    end

    assign crc_o = crc_q;
`endif

    assign cfg_clk_o    = cfg_clk_q;
    assign cfg_value_o  = cfg_value_q;
    assign data_ready_o = (state_q == FETCH);
    assign busy_o       = (state_q == FETCH) || (state_q == SETUP) ||
                          (state_q == HIGH)  || (state_q == HOLD);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_chain_loader
//   Two loaders share a clock: index 0 drives a 5-bit chain, index 1 a 10-bit
//   chain (both 8-bit words, default phase timing). A monitor on the falling
//   clock edge records the bit present at each cfg_clk rise and counts any
//   cfg_value change while cfg_clk is high or in the same cycle as a cfg_clk
//   transition.
// ---------------------------------------------------------------------------
module tb_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_s;
    logic [1:0] valid_s;
    logic [7:0] data_s [2];
    logic [1:0] ready_s;
    logic [1:0] cclk_s;
    logic [1:0] cval_s;
    logic [1:0] busy_s;
    logic [1:0] done_s;
`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc5;
    logic [7:0] crc10;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    int           pulses [2];
    int           hs     [2];
    int           viol   [2];
    logic [511:0] cap    [2];
    logic [1:0]   pclk;
    logic [1:0]   pval;

    always #5 clk = ~clk;

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(5)) u5 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_s[0]),
        .data_i       (data_s[0]),
        .data_valid_i (valid_s[0]),
        .data_ready_o (ready_s[0]),
        .cfg_clk_o    (cclk_s[0]),
        .cfg_value_o  (cval_s[0]),
        .busy_o       (busy_s[0]),
`ifdef CFG_LOADER_CRC_EN
        .crc_o        (crc5),
`endif
        .done_o       (done_s[0])
    );

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(10)) u10 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_s[1]),
        .data_i       (data_s[1]),
        .data_valid_i (valid_s[1]),
        .data_ready_o (ready_s[1]),
        .cfg_clk_o    (cclk_s[1]),
        .cfg_value_o  (cval_s[1]),
        .busy_o       (busy_s[1]),
`ifdef CFG_LOADER_CRC_EN
        .crc_o        (crc10),
`endif
        .done_o       (done_s[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (cclk_s[d] && !pclk[d]) begin
                    cap[d][pulses[d]] = cval_s[d];
                    pulses[d] = pulses[d] + 1;
                end
                if ((cclk_s[d] !== pclk[d]) && (cval_s[d] !== pval[d])) viol[d] = viol[d] + 1;
                if (cclk_s[d] && pclk[d] && (cval_s[d] !== pval[d])) viol[d] = viol[d] + 1;
                if (valid_s[d] && ready_s[d]) hs[d] = hs[d] + 1;
            end
            pclk[d] = cclk_s[d];
            pval[d] = cval_s[d];
        end
    end

    function automatic logic [7:0] crc_model(input logic [511:0] v, input int base, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ v[base + i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic feed(input int d, input logic [7:0] w, output bit ok);
        @(posedge clk); #1;
        data_s[d]  = w;
        valid_s[d] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (ready_s[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        valid_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_s[d]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cclk(input int d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cclk_s[d]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_s = 2'b00;
        valid_s = 2'b00;
        data_s[0] = 8'h00;
        data_s[1] = 8'h00;
        #1;
        n_cmp++; if (cclk_s !== 2'b00) begin n_fail++; $display("FAIL reset_cfg_clk got=%b want=00", cclk_s); end
        n_cmp++; if (cval_s !== 2'b00) begin n_fail++; $display("FAIL reset_cfg_value got=%b want=00", cval_s); end
        n_cmp++; if (ready_s !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b want=00", ready_s); end
        n_cmp++; if (busy_s !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b want=00", busy_s); end
        n_cmp++; if (done_s !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b want=00", done_s); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy_s !== 2'b00 || ready_s !== 2'b00) begin n_fail++; $display("FAIL idle_no_start busy=%b ready=%b want 00/00", busy_s, ready_s); end
    endtask

    task automatic test_single_word;
        int base, hsb, vb, cyc;
        bit ok;
        logic [4:0] got;
        base = pulses[0]; hsb = hs[0]; vb = viol[0];
        pulse_start(0);
        n_cmp++; if (busy_s[0] !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_start got=%b want=1", busy_s[0]); end
        n_cmp++; if (ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL t1_ready_in_fetch got=%b want=1", ready_s[0]); end
        n_cmp++; if (cclk_s[0] !== 1'b0) begin n_fail++; $display("FAIL t1_cfg_clk_wait got=%b want=0", cclk_s[0]); end
        feed(0, 8'b0001_0110, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL t1_handshake_timeout got=0 want=1"); end
        wait_done(0, cyc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL t1_done_timeout got=0 want=1"); end
        n_cmp++; if (cyc !== 15) begin n_fail++; $display("FAIL t1_shift_cycles got=%0d want=15", cyc); end
        got = cap[0][base +: 5];
        n_cmp++; if (got !== 5'b10110) begin n_fail++; $display("FAIL t1_bits got=%b want=10110", got); end
        n_cmp++; if (pulses[0] - base !== 5) begin n_fail++; $display("FAIL t1_pulses got=%0d want=5", pulses[0] - base); end
        n_cmp++; if (hs[0] - hsb !== 1) begin n_fail++; $display("FAIL t1_handshakes got=%0d want=1", hs[0] - hsb); end
        n_cmp++; if (viol[0] - vb !== 0) begin n_fail++; $display("FAIL t1_value_stability got=%0d want=0", viol[0] - vb); end
        n_cmp++; if (cval_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
            n_fail++; $display("FAIL t1_done_outputs value=%b busy=%b ready=%b want 0/0/0", cval_s[0], busy_s[0], ready_s[0]);
        end
    endtask

    task automatic test_two_words;
        int base, hsb, vb, cyc;
        bit ok1, ok2, ok3;
        logic [9:0] got;
        base = pulses[1]; hsb = hs[1]; vb = viol[1];
        pulse_start(1);
        feed(1, 8'hA5, ok1);
        feed(1, 8'h03, ok2);
        wait_done(1, cyc, ok3);
        n_cmp++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL t2_timeout got=%b%b%b want=111", ok1, ok2, ok3); end
        got = cap[1][base +: 10];
        n_cmp++; if (got !== 10'b11_1010_0101) begin n_fail++; $display("FAIL t2_bits got=%b want=1110100101", got); end
        n_cmp++; if (pulses[1] - base !== 10) begin n_fail++; $display("FAIL t2_pulses got=%0d want=10", pulses[1] - base); end
        n_cmp++; if (hs[1] - hsb !== 2) begin n_fail++; $display("FAIL t2_handshakes got=%0d want=2", hs[1] - hsb); end
        n_cmp++; if (viol[1] - vb !== 0) begin n_fail++; $display("FAIL t2_value_stability got=%0d want=0", viol[1] - vb); end
`ifdef CFG_LOADER_CRC_EN
        n_cmp++; if (crc10 !== crc_model(cap[1], base, 10)) begin
            n_fail++; $display("FAIL t2_crc got=%h want=%h", crc10, crc_model(cap[1], base, 10));
        end
`endif
    endtask

    task automatic test_stall;
        int base, bad, cyc;
        bit ok1, ok2, ok3, okr;
        logic saved;
        logic [9:0] got;
        base = pulses[1];
        pulse_start(1);
        feed(1, 8'h5A, ok1);
        okr = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready_s[1]) begin
                okr = 1'b1;
                break;
            end
        end
        n_cmp++; if (!(ok1 && okr)) begin n_fail++; $display("FAIL t3_refetch_timeout got=%b%b want=11", ok1, okr); end
        saved = cval_s[1];
        n_cmp++; if (saved !== 1'b0) begin n_fail++; $display("FAIL t3_last_bit_held got=%b want=0", saved); end
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cclk_s[1] !== 1'b0 || cval_s[1] !== saved || ready_s[1] !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL t3_stall_quiet got=%0d want=0", bad); end
        feed(1, 8'h02, ok2);
        wait_done(1, cyc, ok3);
        n_cmp++; if (!(ok2 && ok3)) begin n_fail++; $display("FAIL t3_timeout got=%b%b want=11", ok2, ok3); end
        got = cap[1][base +: 10];
        n_cmp++; if (got !== 10'b10_0101_1010) begin n_fail++; $display("FAIL t3_bits got=%b want=1001011010", got); end
        n_cmp++; if (pulses[1] - base !== 10) begin n_fail++; $display("FAIL t3_pulses got=%0d want=10", pulses[1] - base); end
    endtask

    task automatic test_reset_mid_load;
        int base, cyc;
        bit ok1, ok2, ok3, ok4, okc;
        logic [9:0] got;
        pulse_start(1);
        feed(1, 8'hFF, ok1);
        wait_cclk(1, okc);
        n_cmp++; if (!(ok1 && okc)) begin n_fail++; $display("FAIL t4_reach_high got=%b%b want=11", ok1, okc); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (cclk_s[1] !== 1'b0) begin n_fail++; $display("FAIL t4_async_cfg_clk got=%b want=0", cclk_s[1]); end
        n_cmp++; if (busy_s[1] !== 1'b0 || cval_s[1] !== 1'b0 || done_s[1] !== 1'b0) begin
            n_fail++; $display("FAIL t4_async_state busy=%b value=%b done=%b want 0/0/0", busy_s[1], cval_s[1], done_s[1]);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        base = pulses[1];
        pulse_start(1);
        feed(1, 8'h0F, ok2);
        feed(1, 8'h02, ok3);
        wait_done(1, cyc, ok4);
        n_cmp++; if (!(ok2 && ok3 && ok4)) begin n_fail++; $display("FAIL t4_reload_timeout got=%b%b%b want=111", ok2, ok3, ok4); end
        got = cap[1][base +: 10];
        n_cmp++; if (got !== 10'b10_0000_1111) begin n_fail++; $display("FAIL t4_reload_bits got=%b want=1000001111", got); end
        n_cmp++; if (pulses[1] - base !== 10) begin n_fail++; $display("FAIL t4_reload_pulses got=%0d want=10", pulses[1] - base); end
    endtask

    task automatic test_start_while_busy;
        int base, cyc;
        bit ok1, ok2, ok3, okc;
        logic [9:0] got;
        base = pulses[1];
        pulse_start(1);
        feed(1, 8'hC3, ok1);
        wait_cclk(1, okc);
        pulse_start(1);
        feed(1, 8'h01, ok2);
        wait_done(1, cyc, ok3);
        n_cmp++; if (!(ok1 && okc && ok2 && ok3)) begin n_fail++; $display("FAIL t5_timeout got=%b%b%b%b want=1111", ok1, okc, ok2, ok3); end
        got = cap[1][base +: 10];
        n_cmp++; if (got !== 10'b01_1100_0011) begin n_fail++; $display("FAIL t5_bits got=%b want=0111000011", got); end
        n_cmp++; if (pulses[1] - base !== 10) begin n_fail++; $display("FAIL t5_pulses got=%0d want=10", pulses[1] - base); end
        repeat (3) @(negedge clk);
        n_cmp++; if (done_s[1] !== 1'b1) begin n_fail++; $display("FAIL t5_done_level got=%b want=1", done_s[1]); end
        pulse_start(1);
        n_cmp++; if (done_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
            n_fail++; $display("FAIL t5_restart done=%b busy=%b want 0/1", done_s[1], busy_s[1]);
        end
        base = pulses[1];
        feed(1, 8'h00, ok1);
        feed(1, 8'h00, ok2);
        wait_done(1, cyc, ok3);
        n_cmp++; if (!(ok1 && ok2 && ok3) || pulses[1] - base !== 10) begin
            n_fail++; $display("FAIL t5_second_load ok=%b%b%b pulses=%0d want 111/10", ok1, ok2, ok3, pulses[1] - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_stall();
        test_reset_mid_load();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
